wb_cmd_master: RTL and testbench

Wishbone classic initiator that turns single-word commands from a valid/ready command port into one Wishbone bus cycle each, returning read data or a timeout error on a valid/ready response port. It sits in the user project area on the `wb_clk_i` domain. It drives the Wishbone slave port of `wb_pio` (or any classic slave) from an on-chip agent such as logic-analyzer glue or a sequencer, alongside the management SoC.

---
 rtl/wb_master_pkg.sv | 12 +
 rtl/wb_cmd_master.sv | 80 ++++++++
 tb/tb_wb_cmd_master.sv | 135 +++++++++++++
 3 files changed

// File: rtl/wb_master_pkg.sv
// wb_master_pkg: shared types and default widths for the Wishbone command master.
package wb_master_pkg;
  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
    logic [WB_DW/8-1:0] sel;
  } wb_cmd_t;
endpackage

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: valid/ready command port to single Wishbone classic cycles with timeout.
module wb_cmd_master
  import wb_master_pkg::*;
#(
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [DW-1:0]   cmd_dat_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_dat_o,
  output logic            rsp_err_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic timeout;
  assign timeout     = cnt == CW'(TIMEOUT - 1);
  assign cmd_ready_o = state == IDLE;
  assign rsp_valid_o = state == RESP;
  assign wbm_cyc_o   = state == BUS;
  assign wbm_stb_o   = state == BUS;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = cmd_valid_i ? BUS : IDLE;
      BUS:     state_n = (wbm_ack_i || timeout) ? RESP : BUS;
      RESP:    state_n = rsp_ready_i ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      rsp_dat_o <= '0;
      rsp_err_o <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && cmd_valid_i) begin
        wbm_we_o  <= cmd_we_i;
        wbm_adr_o <= cmd_adr_i;
        wbm_dat_o <= cmd_dat_i;
        wbm_sel_o <= cmd_sel_i;
        cnt       <= '0;
      end
      if (state == BUS) begin
        // saturating count; an ack in the final cycle still wins over the abort
        if (!wbm_ack_i && cnt != CW'(TIMEOUT)) cnt <= cnt + 1'b1;
        if (wbm_ack_i) begin
          rsp_dat_o <= wbm_we_o ? '0 : wbm_dat_i;
          rsp_err_o <= 1'b0;
        end else if (timeout) begin
          rsp_dat_o <= '0;
          rsp_err_o <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: randomized transfers against a transaction-level model of the master.
module tb_wb_cmd_master;
  import wb_master_pkg::*;
  localparam int TO = 8;
  logic        clk = 0, rst = 1;
  logic        cmd_valid_i = 0, cmd_we_i = 0, rsp_ready_i = 0, wbm_ack_i = 0;
  logic [31:0] cmd_adr_i = 0, cmd_dat_i = 0, wbm_dat_i = 0;
  logic [3:0]  cmd_sel_i = 0;
  logic        cmd_ready_o, rsp_valid_o, rsp_err_o, wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] rsp_dat_o, wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  int errors = 0, checks = 0;

  wb_cmd_master #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_we_o(wbm_we_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_sel_o(wbm_sel_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // d = cycle index of the ack within the stb window (>= TO means the slave never acks)
  task automatic txn(input wb_cmd_t c, input int d, input logic [31:0] rd, input int w);
    int n;
    int estb;
    logic eerr;
    logic [31:0] edat;
    estb = d < TO ? d + 1 : TO;
    eerr = d >= TO;
    edat = (eerr || c.we) ? 32'h0 : rd;
    check("cmd_ready", cmd_ready_o, 1);
    cmd_valid_i = 1; cmd_we_i = c.we; cmd_adr_i = c.adr; cmd_dat_i = c.dat; cmd_sel_i = c.sel;
    tick();
    cmd_valid_i = 0; cmd_we_i = 1'($urandom); cmd_adr_i = $urandom; cmd_dat_i = $urandom;
    cmd_sel_i = 4'($urandom);
    check("stb_rise", {wbm_cyc_o, wbm_stb_o}, 2'b11);
    n = 0;
    while (wbm_stb_o && n < 64) begin
      check("bus_fields", {wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o},
            {1'b1, c.we, c.adr, c.dat, c.sel});
      wbm_ack_i = n == d;
      wbm_dat_i = n == d ? rd : $urandom;
      tick();
      n++;
    end
    wbm_ack_i = 0;
    check("stb_cycles", n, estb);
    check("cyc_low", wbm_cyc_o, 0);
    for (int i = 0; i <= w; i++) begin
      check("rsp_hold", {rsp_valid_o, cmd_ready_o, rsp_err_o, rsp_dat_o}, {1'b1, 1'b0, eerr, edat});
      wbm_ack_i = 1'($urandom);
      rsp_ready_i = i == w;
      tick();
    end
    rsp_ready_i = 0;
    wbm_ack_i = 0;
    check("rsp_done", {rsp_valid_o, cmd_ready_o, wbm_stb_o}, 3'b010);
  endtask

  initial begin
    wb_cmd_t c;
    repeat (2) tick();
    rst = 0;
    tick();
    check("reset_state", {cmd_ready_o, rsp_valid_o, wbm_cyc_o, wbm_stb_o, wbm_we_o},
          5'b10000);
    check("reset_bus", {wbm_adr_o, wbm_dat_o, wbm_sel_o}, 0);
    check("reset_rsp", {rsp_err_o, rsp_dat_o}, 0);
    c = '{we: 1, adr: 32'h3000_0004, dat: 32'hDEAD_BEEF, sel: 4'hF};
    txn(c, 0, 32'h5555_AAAA, 0);
    c = '{we: 0, adr: 32'h3000_0000, dat: 32'h0, sel: 4'hF};
    txn(c, 3, 32'h1234_5678, 0);
    txn(c, TO + 4, 32'h1111_2222, 0);
    txn(c, 1, 32'hCAFE_F00D, 5);
    txn(c, 2, 32'h0BAD_F00D, 0);
    txn(c, TO - 1, 32'h7777_0001, 1);
    // reset during the second stb cycle discards the transfer
    cmd_valid_i = 1; cmd_we_i = 0; cmd_adr_i = 32'h3000_0008; cmd_sel_i = 4'h3;
    tick();
    cmd_valid_i = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    check("rst_mid_bus", {wbm_cyc_o, wbm_stb_o, rsp_valid_o, cmd_ready_o}, 4'b0001);
    check("rst_mid_adr", wbm_adr_o, 0);
    for (int i = 0; i < 3; i++) begin
      wbm_ack_i = 1;
      wbm_dat_i = $urandom;
      tick();
      check("spurious_ack", {rsp_valid_o, cmd_ready_o, wbm_stb_o}, 3'b010);
    end
    wbm_ack_i = 0;
    for (int t = 0; t < 40; t++) begin
      int gap;
      c.we = 1'($urandom);
      c.adr = $urandom;
      c.dat = $urandom;
      c.sel = 4'($urandom);
      txn(c, int'($urandom_range(0, TO + 2)), $urandom, int'($urandom_range(0, 4)));
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        wbm_ack_i = 1'($urandom);
        tick();
        check("idle_ack_ignored", {rsp_valid_o, cmd_ready_o, wbm_stb_o}, 3'b010);
      end
      wbm_ack_i = 0;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
